mux2_rr_arbiter: RTL and testbench
==================================

// Module: mux2_rr_arbiter
// PURPOSE
//   Round-robin arbiter that shares one 2:1 mux channel between two requesters.
//   Drives the mux select from a registered grant FSM and holds a grant for a burst.
//   Forces rotation after MAX_HOLD cycles when the other side is waiting.
//   Sits between the two requesting sources and the shared output channel.
// PARAMETERS
//   WIDTH     1  data width per requester; one 2:1 mux per bit
//   MAX_HOLD  4  max consecutive granted cycles while the other side requests (>=2)
// PORTS
//   clk     in   1      single clock, rising edge
//   rst_n   in   1      asynchronous, active-low reset
//   req0    in   1      requester 0 wants the channel; held high for the whole burst
//   req1    in   1      requester 1 wants the channel
//   d0      in   WIDTH  requester 0 data
//   d1      in   WIDTH  requester 1 data
//   gnt0    out  1      registered grant to requester 0
//   gnt1    out  1      registered grant to requester 1; gnt0&gnt1 never both high
//   sel     out  1      mux select: 0=d0, 1=d1
//   dout    out  WIDTH  shared channel = sel ? d1 : d0 (combinational)
//   dvalid  out  1      (gnt0&req0)|(gnt1&req1)
// BEHAVIOUR
//   Reset (async, immediate, also mid-burst):
//     state=IDLE, gnt0=gnt1=0, sel=0, last=1 (req0 wins first tie), cnt=0, dvalid=0.
//   States: IDLE, GNT0, GNT1. gnt0/gnt1 are decoded from registered state.
//   Grant latency: 1 cycle from sampled req to grant.
//   IDLE:
//     req0&req1 -> grant the side != last.
//     Only one req -> grant that side.
//     None -> stay in IDLE.
//   GNTx:
//     reqx low -> GNTy if reqy, else IDLE. No idle bubble on handover.
//     reqx high, reqy high, cnt==MAX_HOLD-1 -> preempt to GNTy.
//     reqx high, otherwise -> stay in GNTx.
//   cnt, width $clog2(MAX_HOLD):
//     Cleared on every state change.
//     Increments each cycle in GNTx while reqx high.
//     Saturates at MAX_HOLD-1; no preempt while reqy is low.
//   last: set to x on entry to GNTx.
//   sel:
//     0 in GNT0, 1 in GNT1.
//     Holds its previous value in IDLE, so dout does not glitch to the other source.
//   Simultaneous reqx fall and reqy rise in the same cycle -> GNTy next cycle.
//   Preempted requester keeps req high: it re-enters through normal round robin.
//   dout is valid only while dvalid=1; consumers ignore it otherwise.
// STRUCTURE
//   Shared package mux_arb_pkg:
//     State encodings IDLE=2'b00, GNT0=2'b01, GNT1=2'b10.
//     Bit0/bit1 of the state are gnt0/gnt1.
//   Sub-module: generate WIDTH instances of the team's gate-level 2:1 mux (mux).
//     Port order (O,S,I1,I2) = (dout[i], sel, d0[i], d1[i]).
//   FSM, cnt and last live in this module; no behavioural ?: on the data path.
// TESTING
//   1 Reset, then req0=1 only: gnt0=1 one cycle later, sel=0, dout=d0, dvalid=1.
//   2 req0=req1=1 from IDLE right after reset: GNT0 first. With MAX_HOLD=4:
//     - gnt0 is high for exactly 4 cycles.
//     - Then gnt1 for 4 cycles, alternating.
//   3 In GNT0, req1=0: gnt0 is held for 10 cycles with no preempt.
//     req1 rises at cycle 10 -> switch only once cnt reaches 3.
//   4 In GNT0, req0 falls and req1 rises on the same edge:
//     next cycle gnt1=1, sel=1, with no IDLE cycle.
//   5 rst_n low mid-GNT1:
//     - gnt1, dvalid and sel drop asynchronously.
//     - After release with both reqs high, GNT0 is granted first.
//   6 WIDTH=8, d0=8'hA5, d1=8'h3C:
//     - dout tracks sel bitwise.
//     - IDLE after GNT1 keeps dout=8'h3C.
//     - gnt0&gnt1 is never 1 (assertion).

Source files
------------

// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared types and next-state rule for the two-requester round-robin mux arbiter.
// Each grant state has a one-hot encoding. Bit 0 of the state drives gnt0 and
// bit 1 drives gnt1, so the state register doubles as the registered grant pair.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_e;

  // Round-robin next-state rule.
  // last names the requester granted most recently: a tie goes to the other side.
  // hold_done means the current holder has used up its burst allowance.
  function automatic arb_state_e arb_next(
    input arb_state_e cur,
    input logic       req0,
    input logic       req1,
    input logic       last,
    input logic       hold_done
  );
    arb_state_e nxt;
    nxt = cur;
    case (cur)
      IDLE: begin
        if (req0 && req1) nxt = last ? GNT0 : GNT1;
        else if (req0)    nxt = GNT0;
        else if (req1)    nxt = GNT1;
        else              nxt = IDLE;
      end
      GNT0: begin
        if (!req0)                  nxt = req1 ? GNT1 : IDLE;
        else if (req1 && hold_done) nxt = GNT1;
        else                        nxt = GNT0;
      end
      GNT1: begin
        if (!req1)                  nxt = req0 ? GNT0 : IDLE;
        else if (req0 && hold_done) nxt = GNT0;
        else                        nxt = GNT1;
      end
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mux2_rr_arbiter_mux.sv
// Gate-level 2:1 mux for a single bit. When S is low, O follows I1. When S is high, O follows I2.
module mux (
  output logic O,
  input  logic S,
  input  logic I1,
  input  logic I2
);

  logic s_n;
  logic a1;
  logic a2;

  not g_inv (s_n, S);
  and g_and1 (a1, s_n, I1);
  and g_and2 (a2, S, I2);
  or  g_or (O, a1, a2);

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter that shares one 2:1 mux channel between two requesters.
// A grant lasts for a whole burst. If the other side is waiting, the holder is
// forced to give up the channel after MAX_HOLD consecutive cycles.
module mux2_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid
);

  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

  arb_state_e    state;
  arb_state_e    nxt;
  logic [CW-1:0] cnt;
  logic          last;
  logic          stay_busy;

  assign nxt       = arb_next(state, req0, req1, last, cnt == CNT_MAX);
  assign stay_busy = ((state == GNT0) && req0) || ((state == GNT1) && req1);

  // Grant FSM, including the burst counter, the round-robin memory and the registered mux select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
      sel   <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != state) begin
        cnt <= '0;
        if (nxt == GNT0) begin
          last <= 1'b0;
          sel  <= 1'b0;
        end else if (nxt == GNT1) begin
          last <= 1'b1;
          sel  <= 1'b1;
        end
      end else if (stay_busy && (cnt != CNT_MAX)) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign gnt0   = state[0];
  assign gnt1   = state[1];
  assign dvalid = (gnt0 & req0) | (gnt1 & req1);

  // Instantiate one gate-level mux per data bit, so the shared channel carries no behavioural select.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux u_mux (
      .O (dout[i]),
      .S (sel),
      .I1(d0[i]),
      .I2(d1[i])
    );
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter (WIDTH=8, MAX_HOLD=4).
// A channel-ownership model predicts grant, select and data every cycle.
// Directed checks with literal expectations pin down the model's key behaviours.
module tb_mux2_rr_arbiter;

  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic             gnt0;
  logic             gnt1;
  logic             sel;
  logic [WIDTH-1:0] dout;
  logic             dvalid;

  int checkCount = 0;
  int passCount  = 0;
  bit compareEn  = 1'b0;

  // Model state: who owns the channel (-1 means nobody), how many cycles it has held the channel, and the select it last drove.
  int owner      = -1;
  int held       = 0;
  int lastWinner = 1;
  bit selExp     = 1'b0;

  mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (req0),
    .req1  (req1),
    .d0    (d0),
    .d1    (d1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .sel   (sel),
    .dout  (dout),
    .dvalid(dvalid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    else
      passCount++;
  endtask

  task automatic applyStimulus(input logic r0, input logic r1, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(posedge clk);
    #1;
    req0 = r0;
    req1 = r1;
    d0   = a;
    d1   = b;
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Ownership model. In IDLE, a tie goes to the side that did not win last.
  // The owner keeps the channel until it drops its request, or until the other
  // side is waiting and the owner has already held the channel for MAX_HOLD cycles.
  always @(posedge clk or negedge rst_n) begin
    int nxt;
    int other;
    bit r [2];
    if (!rst_n) begin
      owner      = -1;
      held       = 0;
      lastWinner = 1;
      selExp     = 1'b0;
    end else begin
      r[0] = req0;
      r[1] = req1;
      if (owner < 0) begin
        if (r[0] && r[1]) nxt = 1 - lastWinner;
        else if (r[0])    nxt = 0;
        else if (r[1])    nxt = 1;
        else              nxt = -1;
      end else begin
        other = 1 - owner;
        if (!r[owner])                          nxt = r[other] ? other : -1;
        else if (r[other] && held >= MAX_HOLD)  nxt = other;
        else                                    nxt = owner;
      end
      if (nxt >= 0 && nxt == owner) begin
        held++;
      end else if (nxt >= 0) begin
        held       = 1;
        lastWinner = nxt;
        selExp     = (nxt == 1);
      end else begin
        held = 0;
      end
      owner = nxt;
    end
  end

  // On every negedge, compare the DUT outputs against the model.
  always @(negedge clk) begin
    if (compareEn) begin
      checkOutput("gnt0",   {31'd0, gnt0},   {31'd0, owner == 0});
      checkOutput("gnt1",   {31'd0, gnt1},   {31'd0, owner == 1});
      checkOutput("sel",    {31'd0, sel},    {31'd0, selExp});
      checkOutput("dvalid", {31'd0, dvalid}, {31'd0, (owner == 0 && req0) || (owner == 1 && req1)});
      checkOutput("dout",   {24'd0, dout},   {24'd0, selExp ? d1 : d0});
      checkOutput("mutex",  {31'd0, gnt0 & gnt1}, 32'd0);
    end
  end

  // The two grants must never be high at the same time.
  always @(posedge clk) begin
    if (rst_n === 1'b1)
      assert (!(gnt0 && gnt1)) else $error("[TB] FAIL mutex assertion: both grants high at %0t", $time);
  end

  initial begin
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    d0    = 8'hA5;
    d1    = 8'h3C;
    #2;
    compareEn = 1'b1;
    #10;
    checkOutput("reset gnt0",   {31'd0, gnt0},   32'd0);
    checkOutput("reset gnt1",   {31'd0, gnt1},   32'd0);
    checkOutput("reset sel",    {31'd0, sel},    32'd0);
    checkOutput("reset dvalid", {31'd0, dvalid}, 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // When only req0 is asserted, the grant arrives one cycle later.
    applyStimulus(1'b1, 1'b0, 8'hA5, 8'h3C);
    @(posedge clk); #1;
    checkOutput("t1 gnt0",   {31'd0, gnt0},   32'd1);
    checkOutput("t1 sel",    {31'd0, sel},    32'd0);
    checkOutput("t1 dout",   {24'd0, dout},   32'hA5);
    checkOutput("t1 dvalid", {31'd0, dvalid}, 32'd1);

    // When both sides request straight after reset, each gets bursts of four cycles, starting with side 0.
    pulseReset();
    applyStimulus(1'b1, 1'b1, 8'hA5, 8'h3C);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      checkOutput("t2 gnt0", {31'd0, gnt0}, {31'd0, ((i / 4) % 2) == 0});
      checkOutput("t2 gnt1", {31'd0, gnt1}, {31'd0, ((i / 4) % 2) == 1});
    end

    // With no competitor, side 0 holds the channel. When req1 arrives, the saturated count hands over at once.
    pulseReset();
    applyStimulus(1'b1, 1'b0, 8'hA5, 8'h3C);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput("t3 hold gnt0", {31'd0, gnt0}, 32'd1);
    end
    applyStimulus(1'b1, 1'b1, 8'hA5, 8'h3C);
    @(posedge clk); #1;
    checkOutput("t3 preempt gnt1", {31'd0, gnt1}, 32'd1);

    // When req0 falls and req1 rises on the same edge, the channel passes to side 1 with no idle cycle.
    pulseReset();
    applyStimulus(1'b1, 1'b0, 8'hA5, 8'h3C);
    @(posedge clk); #1;
    checkOutput("t4 gnt0", {31'd0, gnt0}, 32'd1);
    applyStimulus(1'b0, 1'b1, 8'hA5, 8'h3C);
    @(posedge clk); #1;
    checkOutput("t4 gnt1", {31'd0, gnt1}, 32'd1);
    checkOutput("t4 gnt0", {31'd0, gnt0}, 32'd0);
    checkOutput("t4 sel",  {31'd0, sel},  32'd1);

    // Asserting reset in the middle of a GNT1 burst clears the outputs without waiting for a clock edge.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("t5 gnt1",   {31'd0, gnt1},   32'd0);
    checkOutput("t5 dvalid", {31'd0, dvalid}, 32'd0);
    checkOutput("t5 sel",    {31'd0, sel},    32'd0);
    req0 = 1'b1;
    req1 = 1'b1;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("t5 gnt0 first", {31'd0, gnt0}, 32'd1);

    // When the channel goes idle after side 1, the select stays on d1.
    applyStimulus(1'b0, 1'b1, 8'hA5, 8'h3C);
    @(posedge clk); #1;
    checkOutput("t6 gnt1", {31'd0, gnt1}, 32'd1);
    applyStimulus(1'b0, 1'b0, 8'hA5, 8'h3C);
    @(posedge clk); #1;
    checkOutput("t6 idle gnt1", {31'd0, gnt1},   32'd0);
    checkOutput("t6 idle sel",  {31'd0, sel},    32'd1);
    checkOutput("t6 idle dout", {24'd0, dout},   32'h3C);
    checkOutput("t6 dvalid",    {31'd0, dvalid}, 32'd0);

    // Random requests and data. Each request tends to stay high for a while, so bursts and preemptions both occur.
    for (int i = 0; i < 400; i++) begin
      logic r0n;
      logic r1n;
      r0n = ($urandom_range(0, 3) == 0) ? ~req0 : req0;
      r1n = ($urandom_range(0, 3) == 0) ? ~req1 : req1;
      applyStimulus(r0n, r1n, WIDTH'($urandom), WIDTH'($urandom));
    end

    @(negedge clk);
    @(negedge clk);
    compareEn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
